// File: rtl/badge_io_pkg.sv
// Shared definitions for the badge button input path: event codes, slot mapping, FSM states.
package badge_io_pkg;

  localparam int unsigned NUM_BTN   = 8;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned EVT_W     = 5;
  localparam int unsigned EVT_KINDS = 3;
  localparam int unsigned NUM_SLOTS = NUM_BTN * EVT_KINDS;
  localparam int unsigned SLOT_W    = $clog2(NUM_SLOTS);

  localparam int unsigned K_PRESS   = 0;
  localparam int unsigned K_LONG    = 1;
  localparam int unsigned K_RELEASE = 2;

  localparam logic [1:0] EVT_PRESS   = 2'b01;
  localparam logic [1:0] EVT_LONG    = 2'b11;
  localparam logic [1:0] EVT_RELEASE = 2'b10;

  typedef enum logic [1:0] {
    ST_REL = 2'd0,
    ST_PRS = 2'd1,
    ST_LNG = 2'd2
  } btn_state_e;

  typedef struct packed {
    logic [1:0]       typ;
    logic [IDX_W-1:0] idx;
  } evt_code_t;

  // Pending-vector position of an event: lower slots win arbitration.
  function automatic int unsigned slot_index(input int unsigned idx, input int unsigned kind);
    return idx * EVT_KINDS + kind;
  endfunction

  function automatic evt_code_t slot_code(input int unsigned slot);
    evt_code_t c;
    c.idx = IDX_W'(slot / EVT_KINDS);
    case (slot % EVT_KINDS)
      K_PRESS: c.typ = EVT_PRESS;
      K_LONG:  c.typ = EVT_LONG;
      default: c.typ = EVT_RELEASE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/btn_debounce_fsm.sv
// Per-button debounce and hold tracker, advanced only on divided ticks.
// Event outputs are single-cycle strobes aligned with the accepting tick.
module btn_debounce_fsm
  import badge_io_pkg::*;
#(
  parameter int unsigned DEB_TICKS  = 10,
  parameter int unsigned LONG_TICKS = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_c_o,
  output logic long_c_o,
  output logic release_c_o
);

  localparam int unsigned DEB_W  = $clog2(DEB_TICKS + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_TICKS + 1);

  btn_state_e        state_q, state_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              level_q, level_d;

  logic              deb_done;
  logic              hold_done;
  logic              rel_go;
  logic [DEB_W-1:0]  deb_inc;
  logic [HOLD_W-1:0] hold_inc;

  assign deb_done  = (deb_cnt_q == DEB_W'(DEB_TICKS - 1));
  assign hold_done = (hold_cnt_q == HOLD_W'(LONG_TICKS - 1));
  assign rel_go    = !raw_i && deb_done;
  // Both counters stop at their ceiling instead of wrapping.
  assign deb_inc   = (deb_cnt_q == DEB_W'(DEB_TICKS)) ? deb_cnt_q : deb_cnt_q + 1'b1;
  assign hold_inc  = (hold_cnt_q == HOLD_W'(LONG_TICKS)) ? hold_cnt_q : hold_cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_REL;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      level_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      level_q    <= level_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    deb_cnt_d  = deb_cnt_q;
    hold_cnt_d = hold_cnt_q;
    if (tick_i) begin
      unique case (state_q)
        ST_REL: begin
          if (!raw_i) begin
            deb_cnt_d = '0;
          end else if (deb_done) begin
            state_d    = ST_PRS;
            deb_cnt_d  = '0;
            hold_cnt_d = '0;
          end else begin
            deb_cnt_d = deb_inc;
          end
        end
        ST_PRS, ST_LNG: begin
          if (raw_i) begin
            deb_cnt_d = '0;
          end else if (rel_go) begin
            state_d   = ST_REL;
            deb_cnt_d = '0;
          end else begin
            deb_cnt_d = deb_inc;
          end
          // A release accepted on the same tick suppresses the long event.
          if (state_q == ST_PRS) begin
            hold_cnt_d = hold_inc;
            if (hold_done && !rel_go) state_d = ST_LNG;
          end
        end
        default: begin
          state_d    = ST_REL;
          deb_cnt_d  = '0;
          hold_cnt_d = '0;
        end
      endcase
    end
    level_d = (state_d != ST_REL);
  end

  always_comb begin
    press_c_o   = (state_q == ST_REL) && (state_d == ST_PRS);
    long_c_o    = (state_q == ST_PRS) && (state_d == ST_LNG);
    release_c_o = (state_q != ST_REL) && (state_d == ST_REL);
    level_o     = level_q;
  end

endmodule

// File: rtl/button_event_reader.sv
// Badge button reader: synchronise, debounce on a shared tick, and queue
// press/long/release events through a pending vector and a small FIFO.
module button_event_reader
  import badge_io_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 8000,
  parameter int unsigned DEB_TICKS  = 10,
  parameter int unsigned LONG_TICKS = 500,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] nbtn,
  output logic [NUM_BTN-1:0] btn_level,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [EVT_W-1:0]   evt_code,
  output logic               overflow
);

  localparam int unsigned DIV_W = $clog2(TICK_DIV + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [NUM_BTN-1:0]   sync1_q, sync2_q;
  logic [DIV_W-1:0]     div_q;
  logic                 tick_c;

  logic [NUM_BTN-1:0]   press_c, long_c, release_c;
  logic [NUM_SLOTS-1:0] pend_q, pend_d, pend_set_c, pend_clr_c;
  logic                 overflow_q;

  logic                 grant_vld_c;
  logic [SLOT_W-1:0]    grant_slot_c;
  evt_code_t            grant_code_c;

  evt_code_t            mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 full_c, push_c, pop_c;
  logic                 evt_valid_q;
  evt_code_t            evt_code_q, evt_code_d;

  // Two-flop synchroniser, inverted so 1 = pressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ~nbtn;
      sync2_q <= sync1_q;
    end
  end

  assign tick_c = (div_q == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)         div_q <= '0;
    else if (tick_c) div_q <= '0;
    else             div_q <= div_q + 1'b1;
  end

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    btn_debounce_fsm #(
      .DEB_TICKS  (DEB_TICKS),
      .LONG_TICKS (LONG_TICKS)
    ) u_fsm (
      .clk         (clk),
      .rst         (rst),
      .tick_i      (tick_c),
      .raw_i       (sync2_q[gi]),
      .level_o     (btn_level[gi]),
      .press_c_o   (press_c[gi]),
      .long_c_o    (long_c[gi]),
      .release_c_o (release_c[gi])
    );
  end

  always_comb begin
    pend_set_c = '0;
    for (int unsigned b = 0; b < NUM_BTN; b++) begin
      pend_set_c[SLOT_W'(slot_index(b, K_PRESS))]   = press_c[b];
      pend_set_c[SLOT_W'(slot_index(b, K_LONG))]    = long_c[b];
      pend_set_c[SLOT_W'(slot_index(b, K_RELEASE))] = release_c[b];
    end
  end

  // Fixed-priority arbiter: lowest-numbered pending slot goes first.
  always_comb begin
    grant_vld_c  = 1'b0;
    grant_slot_c = '0;
    for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
      if (!grant_vld_c && pend_q[s]) begin
        grant_vld_c  = 1'b1;
        grant_slot_c = SLOT_W'(s);
      end
    end
    grant_code_c = slot_code(32'(grant_slot_c));
  end

  assign full_c = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign push_c = grant_vld_c && !full_c;
  assign pop_c  = evt_valid_q && evt_ready;

  // A new set wins over a same-cycle clear; a set on a still-pending slot is lost.
  always_comb begin
    pend_clr_c = push_c ? (NUM_SLOTS'(1) << grant_slot_c) : '0;
    pend_d     = (pend_q & ~pend_clr_c) | pend_set_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      overflow_q <= overflow_q | (|(pend_set_c & pend_q & ~pend_clr_c));
    end
  end

  always_comb begin
    rd_ptr_d = pop_c ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
    // Head after this cycle: the entry being written if it lands at the new read pointer.
    if (push_c && (wr_ptr_q == rd_ptr_d)) evt_code_d = grant_code_c;
    else                                  evt_code_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= '0;
    end else begin
      if (push_c) begin
        mem_q[wr_ptr_q] <= grant_code_c;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      evt_valid_q <= (cnt_d != '0);
      evt_code_q  <= evt_code_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_button_event_reader.sv
// Scoreboard bench for button_event_reader: a tick-level behavioural model
// predicts the event stream; a monitor pops and compares each accepted event.
module tb_button_event_reader;

  localparam int unsigned TICK_DIV   = 4;
  localparam int unsigned DEB_TICKS  = 3;
  localparam int unsigned LONG_TICKS = 8;
  localparam int unsigned FIFO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] nbtn = 8'hFF;
  logic [7:0] btn_level;
  logic       evt_valid;
  logic       evt_ready = 1'b1;
  logic [4:0] evt_code;
  logic       overflow;

  button_event_reader #(
    .TICK_DIV   (TICK_DIV),
    .DEB_TICKS  (DEB_TICKS),
    .LONG_TICKS (LONG_TICKS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .nbtn      (nbtn),
    .btn_level (btn_level),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [4:0]  exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: accepted level flips after DEB_TICKS consecutive disagreeing
  // ticks; a long event fires once LONG_TICKS ticks after an accepted press.
  bit         m_level[8];
  int         m_run[8];
  int         m_held[8];
  bit         m_long[8];
  logic [7:0] d1, d2;
  int         edge_cnt;

  task automatic model_tick(input logic [7:0] raw);
    for (int b = 0; b < 8; b++) begin
      if (raw[b] != m_level[b]) m_run[b]++;
      else                      m_run[b] = 0;
      if (m_run[b] == DEB_TICKS) begin
        m_level[b] = raw[b];
        m_run[b]   = 0;
        m_held[b]  = 0;
        m_long[b]  = 1'b0;
        exp_q.push_back({raw[b] ? 2'b01 : 2'b10, 3'(b)});
      end else if (m_level[b] && !m_long[b]) begin
        m_held[b]++;
        if (m_held[b] == LONG_TICKS) begin
          m_long[b] = 1'b1;
          exp_q.push_back({2'b11, 3'(b)});
        end
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 8; b++) begin
        m_level[b] = 1'b0; m_run[b] = 0; m_held[b] = 0; m_long[b] = 1'b0;
      end
      d1 = '0; d2 = '0; edge_cnt = 0;
      exp_q.delete();
    end else begin
      edge_cnt++;
      // Pressed state reaches the debouncer two clocks after it is sampled.
      if (edge_cnt % TICK_DIV == 0) model_tick(d2);
      d2 = d1;
      d1 = ~nbtn;
    end
  end

  function automatic logic [7:0] model_levels();
    logic [7:0] v;
    for (int b = 0; b < 8; b++) v[b] = m_level[b];
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      check("btn_level", 32'(btn_level), 32'(model_levels()));
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL evt_unexpected: got code %b, required no event (t=%0t)", evt_code, $time);
        end else begin
          check("evt_code", 32'(evt_code), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_level(input int b, input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      seen = btn_level[b];
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL wait_level%0d: level 0 after %0d cycles, required 1", b, bound);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step(3);
    check("rst_level", 32'(btn_level), 0);
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_code", 32'(evt_code), 0);
    check("rst_overflow", 32'(overflow), 0);
    rst = 1'b0;
    step(4);

    // 1: clean long hold of button 2, with press-to-valid latency check
    nbtn[2] = 1'b0;
    wait_level(2, 40);
    check("t1_lat_cycle1", 32'(evt_valid), 0);
    @(negedge clk);
    check("t1_lat_cycle2", 32'(evt_valid), 1);
    step(20 * TICK_DIV);
    nbtn[2] = 1'b1;
    step(10 * TICK_DIV);
    check("t1_drained", exp_q.size(), 0);
    check("t1_overflow", 32'(overflow), 0);

    // 2: chatter on button 0 never settles
    for (int i = 0; i < 12; i++) begin
      nbtn[0] = ~nbtn[0];
      step(TICK_DIV);
    end
    nbtn[0] = 1'b1;
    step(6 * TICK_DIV);
    check("t2_level0", 32'(btn_level[0]), 0);
    check("t2_drained", exp_q.size(), 0);

    // 3: simultaneous press of buttons 5 and 1
    nbtn[5] = 1'b0;
    nbtn[1] = 1'b0;
    step(6 * TICK_DIV);
    nbtn[5] = 1'b1;
    nbtn[1] = 1'b1;
    step(8 * TICK_DIV);
    check("t3_drained", exp_q.size(), 0);

    // 4: back-pressure with five simultaneous presses
    evt_ready = 1'b0;
    nbtn[4:0] = 5'b00000;
    step(4 * TICK_DIV);
    check("t4_valid", 32'(evt_valid), 1);
    check("t4_overflow", 32'(overflow), 0);
    evt_ready = 1'b1;
    step(8);
    check("t4_drained", exp_q.size(), 0);
    nbtn = 8'hFF;
    step(10 * TICK_DIV);
    check("t4_rel_drained", exp_q.size(), 0);

    // 5: full FIFO, repeat press of button 3 overflows the pending slot
    pulse_reset();
    evt_ready = 1'b0;
    nbtn = 8'b1110_1000;
    step(6 * TICK_DIV);
    check("t5_valid", 32'(evt_valid), 1);
    nbtn[3] = 1'b0;
    step(5 * TICK_DIV);
    nbtn[3] = 1'b1;
    step(5 * TICK_DIV);
    check("t5_no_ovf_yet", 32'(overflow), 0);
    nbtn[3] = 1'b0;
    step(5 * TICK_DIV);
    check("t5_overflow", 32'(overflow), 1);
    step(4 * TICK_DIV);
    check("t5_sticky", 32'(overflow), 1);
    nbtn = 8'hFF;
    pulse_reset();
    check("t5_ovf_cleared", 32'(overflow), 0);
    evt_ready = 1'b1;
    step(4);

    // 6: reset while button 6 is held with its press still queued
    evt_ready = 1'b0;
    nbtn[6] = 1'b0;
    wait_level(6, 40);
    step(4);
    check("t6_queued", 32'(evt_valid), 1);
    pulse_reset();
    check("t6_rst_level", 32'(btn_level), 0);
    check("t6_rst_valid", 32'(evt_valid), 0);
    evt_ready = 1'b1;
    step(6 * TICK_DIV);
    check("t6_repress_drained", exp_q.size(), 0);
    check("t6_level6", 32'(btn_level[6]), 1);
    nbtn[6] = 1'b1;
    step(6 * TICK_DIV);

    // Randomised activity on buttons 0..3 with the consumer always ready
    for (int seg = 0; seg < 80; seg++) begin
      nbtn = {4'hF, 4'($urandom)};
      step(int'($urandom_range(1, 40)));
    end
    nbtn = 8'hFF;
    step(15 * TICK_DIV);
    check("rand_drained", exp_q.size(), 0);
    check("rand_overflow", 32'(overflow), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
